// File: rtl/zone_alarm_ctrl.sv
// zone_alarm_ctrl
//   Multi-zone intrusion alarm controller. A remote button arms/disarms the
//   system with release-to-act behaviour; enabled zones trigger an entry
//   delay (or the siren directly for instant zones), and the siren re-arms
//   automatically after a fixed duration.
//
// Ports
//   clk      in   clock, rising edge
//   rst      in   asynchronous reset, active-low
//   remote   in   remote button level, 1 = pressed
//   sensor   in   [NZ] per-zone sensor level, 1 = violated
//   zone_en  in   [NZ] per-zone enable
//   alarm    out  siren drive (SIREN state)
//   armed    out  armed indicator (ARMED/ENTRY/SIREN)
//   tripped  out  [NZ] zones violated since last arming
//   pending  out  entry delay running (ENTRY state)
module zone_alarm_ctrl #(
  parameter int              NZ           = 4,
  parameter logic [NZ-1:0]   INSTANT_MASK = '0,
  parameter int              ENTRY_CYC    = 8,
  parameter int              SIREN_CYC    = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          remote,
  input  logic [NZ-1:0] sensor,
  input  logic [NZ-1:0] zone_en,
  output logic          alarm,
  output logic          armed,
  output logic [NZ-1:0] tripped,
  output logic          pending
);

  localparam int MAXC = (ENTRY_CYC > SIREN_CYC) ? ENTRY_CYC : SIREN_CYC;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [CW-1:0] ENTRY_LOAD = CW'(ENTRY_CYC - 1);
  localparam logic [CW-1:0] SIREN_LOAD = CW'(SIREN_CYC - 1);

  typedef enum logic [2:0] {
    S_DISARMED  = 3'd0,
    S_ARMING    = 3'd1,
    S_ARMED     = 3'd2,
    S_ENTRY     = 3'd3,
    S_SIREN     = 3'd4,
    S_DISARMING = 3'd5
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_next;
  logic [NZ-1:0] r_tripped;
  logic [NZ-1:0] w_tripped_next;
  logic [NZ-1:0] w_act;
  logic [NZ-1:0] w_inst;
  logic          w_any_act;
  logic          w_any_inst;

  assign w_act      = sensor & zone_en;
  assign w_inst     = w_act & INSTANT_MASK;
  assign w_any_act  = |w_act;
  assign w_any_inst = |w_inst;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_DISARMED;
      r_cnt     <= '0;
      r_tripped <= '0;
    end else begin
      r_state   <= w_next;
      r_cnt     <= w_cnt_next;
      r_tripped <= w_tripped_next;
    end
  end

  // The counter is loaded on the edge that enters ENTRY/SIREN, so the
  // terminal test (cnt == 0) sits in the state that owns the countdown.
  always_comb begin
    w_next         = r_state;
    w_cnt_next     = r_cnt;
    w_tripped_next = r_tripped;
    case (r_state)
      S_DISARMED: begin
        if (remote) begin
          w_next         = S_ARMING;
          w_tripped_next = '0;
        end
      end
      S_ARMING: begin
        if (!remote) w_next = S_ARMED;
      end
      S_ARMED: begin
        w_tripped_next = r_tripped | w_act;
        if (remote) begin
          w_next     = S_DISARMING;
          w_cnt_next = '0;
        end else if (w_any_inst) begin
          w_next     = S_SIREN;
          w_cnt_next = SIREN_LOAD;
        end else if (w_any_act) begin
          w_next     = S_ENTRY;
          w_cnt_next = ENTRY_LOAD;
        end
      end
      S_ENTRY: begin
        w_tripped_next = r_tripped | w_act;
        if (remote) begin
          w_next     = S_DISARMING;
          w_cnt_next = '0;
        end else if (w_any_inst || (r_cnt == '0)) begin
          w_next     = S_SIREN;
          w_cnt_next = SIREN_LOAD;
        end else begin
          w_cnt_next = r_cnt - 1'b1;
        end
      end
      S_SIREN: begin
        w_tripped_next = r_tripped | w_act;
        if (remote) begin
          w_next     = S_DISARMING;
          w_cnt_next = '0;
        end else if (r_cnt == '0) begin
          w_next = S_ARMED;
        end else begin
          w_cnt_next = r_cnt - 1'b1;
        end
      end
      S_DISARMING: begin
        if (!remote) w_next = S_DISARMED;
      end
      default: begin
        w_next     = S_DISARMED;
        w_cnt_next = '0;
      end
    endcase
  end

  assign alarm   = (r_state == S_SIREN);
  assign armed   = (r_state == S_ARMED) || (r_state == S_ENTRY) || (r_state == S_SIREN);
  assign pending = (r_state == S_ENTRY);
  assign tripped = r_tripped;

endmodule
